// File: rtl/temp_disp_pkg.sv
`default_nettype none
// ============================================================================
// Package : temp_disp_pkg
// Brief   : Shared FSM states, range limits and tenths table for the display path
// Rev     : 1.0  initial release
// ============================================================================
package temp_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ABS  = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] TEMP_MAX_RAW = 16'h07D0;
  localparam logic [15:0] TEMP_MIN_RAW = 16'hFC90;
  localparam int          BCD_DIGIT_W  = 4;

  // Entry f (bits [4f+3:4f]) holds floor(f*10/16): truncation, never rounding up.
  localparam logic [63:0] TENTHS_LUT = {
    4'd9, 4'd8, 4'd8, 4'd7, 4'd6, 4'd6, 4'd5, 4'd5,
    4'd4, 4'd3, 4'd3, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0
  };

  function automatic logic [3:0] tenths_of(input logic [3:0] frac);
    return TENTHS_LUT[{frac, 2'b00} +: 4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// Module : bcd_add3
// Brief  : Double-dabble nibble correction (add 3 when the digit is 5 or more)
// Rev    : 1.0  initial release
// ============================================================================
module bcd_add3
  import temp_disp_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_nib,
  output logic [BCD_DIGIT_W-1:0] o_nib
);

  assign o_nib = (i_nib >= BCD_DIGIT_W'(5)) ? (i_nib + BCD_DIGIT_W'(3)) : i_nib;

endmodule
`default_nettype wire

// File: rtl/temp_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module : temp_bcd_conv
// Brief  : DS18B20 raw reading to signed BCD digits with range flag
// Rev    : 1.0  initial release
// ============================================================================
module temp_bcd_conv
  import temp_disp_pkg::*;
#(
  parameter int INT_BITS  = 7,
  parameter int FRAC_BITS = 4
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        raw_valid,
  input  logic [15:0] raw,
  output logic        busy,
  output logic        bcd_valid,
  output logic        sign,
  output logic [3:0]  d_hund,
  output logic [3:0]  d_tens,
  output logic [3:0]  d_units,
  output logic [3:0]  d_tenth,
  output logic        range_err
);

  localparam int c_NIBBLES = 3;
  localparam int c_BCD_W   = c_NIBBLES * BCD_DIGIT_W;
  localparam int c_SHIFT_W = c_BCD_W + INT_BITS;
  localparam int c_MAG_W   = INT_BITS + FRAC_BITS;
  localparam int c_CNT_W   = $clog2(INT_BITS + 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [15:0]          r_raw;
  logic [c_SHIFT_W-1:0] r_shift;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [3:0]           r_tenth;
  logic                 r_err;

  logic                 r_busy;
  logic                 r_bcd_valid;
  logic                 r_sign;
  logic [3:0]           r_d_hund;
  logic [3:0]           r_d_tens;
  logic [3:0]           r_d_units;
  logic [3:0]           r_d_tenth;
  logic                 r_range_err;

  logic                 w_accept;
  logic [c_MAG_W-1:0]   w_mag;
  logic                 w_range;
  logic [c_BCD_W-1:0]   w_corr;
  logic [c_SHIFT_W-1:0] w_shift_next;
  logic [3:0]           w_hund;
  logic [3:0]           w_tens;
  logic [3:0]           w_units;

  // The registered busy also covers the DONE-output cycle, so gating on it drops that strobe.
  assign w_accept = raw_valid && (r_state == IDLE) && !r_busy;

  // Negating only the low bits gives the same result as the low bits of a 16-bit negate.
  assign w_mag   = r_raw[15] ? (c_MAG_W'(0) - r_raw[c_MAG_W-1:0]) : r_raw[c_MAG_W-1:0];
  assign w_range = ($signed(r_raw) > $signed(TEMP_MAX_RAW)) ||
                   ($signed(r_raw) < $signed(TEMP_MIN_RAW));

  for (genvar gi = 0; gi < c_NIBBLES; gi++) begin : g_nib
    bcd_add3 u_add3 (
      .i_nib (r_shift[INT_BITS + gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_nib (w_corr[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign w_shift_next = {w_corr, r_shift[INT_BITS-1:0]} << 1;

  assign w_hund  = r_shift[INT_BITS + 2*BCD_DIGIT_W +: BCD_DIGIT_W];
  assign w_tens  = r_shift[INT_BITS +   BCD_DIGIT_W +: BCD_DIGIT_W];
  assign w_units = r_shift[INT_BITS                 +: BCD_DIGIT_W];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = ABS;
      ABS:     w_state_next = CONV;
      CONV:    if (r_cnt == c_CNT_W'(INT_BITS - 1)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_raw       <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_tenth     <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_bcd_valid <= 1'b0;
      r_sign      <= 1'b0;
      r_d_hund    <= '0;
      r_d_tens    <= '0;
      r_d_units   <= '0;
      r_d_tenth   <= '0;
      r_range_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_busy      <= (r_state != IDLE);
      r_bcd_valid <= (r_state == DONE);
      if (w_accept) r_raw <= raw;
      case (r_state)
        ABS: begin
          r_shift <= {c_BCD_W'(0), w_mag[FRAC_BITS +: INT_BITS]};
          r_tenth <= tenths_of(w_mag[FRAC_BITS-1 -: 4]);
          r_err   <= w_range;
          r_cnt   <= '0;
        end
        CONV: begin
          r_shift <= w_shift_next;
          r_cnt   <= r_cnt + 1'b1;
        end
        DONE: begin
          r_range_err <= r_err;
          if (r_err) begin
            r_sign    <= 1'b0;
            r_d_hund  <= '0;
            r_d_tens  <= '0;
            r_d_units <= '0;
            r_d_tenth <= '0;
          end else begin
            // A reading that rounds to all-zero digits is shown unsigned.
            r_sign    <= r_raw[15] && (|{w_hund, w_tens, w_units, r_tenth});
            r_d_hund  <= w_hund;
            r_d_tens  <= w_tens;
            r_d_units <= w_units;
            r_d_tenth <= r_tenth;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign bcd_valid = r_bcd_valid;
  assign sign      = r_sign;
  assign d_hund    = r_d_hund;
  assign d_tens    = r_d_tens;
  assign d_units   = r_d_units;
  assign d_tenth   = r_d_tenth;
  assign range_err = r_range_err;

endmodule
`default_nettype wire

// File: tb/tb_temp_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module : tb_temp_bcd_conv
// Brief  : Self-checking bench: directed table, corner sequences, random vs model
// Rev    : 1.0  initial release
// ============================================================================
module tb_temp_bcd_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        raw_valid;
  logic [15:0] raw;
  logic        busy, bcd_valid, sign, range_err;
  logic [3:0]  d_hund, d_tens, d_units, d_tenth;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] raw;
    logic        sign;
    logic [3:0]  hund;
    logic [3:0]  tens;
    logic [3:0]  units;
    logic [3:0]  tenth;
    logic        err;
  } vec_t;

  temp_bcd_conv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_valid (raw_valid),
    .raw       (raw),
    .busy      (busy),
    .bcd_valid (bcd_valid),
    .sign      (sign),
    .d_hund    (d_hund),
    .d_tens    (d_tens),
    .d_units   (d_units),
    .d_tenth   (d_tenth),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference built from temperature arithmetic: degrees in sixteenths, decimal digits by div/mod.
  function automatic vec_t model(input logic [15:0] r);
    vec_t e;
    int   v, m, ip, t;
    e = '{raw: r, sign: 1'b0, hund: 4'd0, tens: 4'd0, units: 4'd0, tenth: 4'd0, err: 1'b0};
    v = int'($signed(r));
    if (v > 125 * 16 || v < -55 * 16) begin
      e.err = 1'b1;
    end else begin
      m       = (v < 0) ? -v : v;
      ip      = m / 16;
      t       = ((m % 16) * 10) / 16;
      e.hund  = 4'(ip / 100);
      e.tens  = 4'((ip / 10) % 10);
      e.units = 4'(ip % 10);
      e.tenth = 4'(t);
      e.sign  = (v < 0) && (ip != 0 || t != 0);
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge where bcd_valid is seen (or the bound expires).
  task automatic convert(input logic [15:0] r, output int lat, output logic busy_gap);
    raw       = r;
    raw_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    raw_valid = 1'b0;
    lat       = 0;
    busy_gap  = 1'b0;
    while (!bcd_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!busy) busy_gap = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    check($sformatf("%s sign raw=%h", tag, e.raw),  sign,      e.sign);
    check($sformatf("%s hund raw=%h", tag, e.raw),  d_hund,    e.hund);
    check($sformatf("%s tens raw=%h", tag, e.raw),  d_tens,    e.tens);
    check($sformatf("%s units raw=%h", tag, e.raw), d_units,   e.units);
    check($sformatf("%s tenth raw=%h", tag, e.raw), d_tenth,   e.tenth);
    check($sformatf("%s err raw=%h", tag, e.raw),   range_err, e.err);
  endtask

  task automatic run_vec(input string tag, input vec_t e);
    int   lat;
    logic gap;
    convert(e.raw, lat, gap);
    check($sformatf("%s latency raw=%h", tag, e.raw), lat, 9);
    check($sformatf("%s busy_gap raw=%h", tag, e.raw), gap, 0);
    check_outputs(tag, e);
    @(negedge clk);
    check($sformatf("%s valid_pulse raw=%h", tag, e.raw), bcd_valid, 0);
    check($sformatf("%s busy_release raw=%h", tag, e.raw), busy, 0);
  endtask

  localparam int N_VEC = 23;
  vec_t vecs [N_VEC];
  int   tenth_tab [16] = '{0, 0, 1, 1, 2, 3, 3, 4, 5, 5, 6, 6, 7, 8, 8, 9};
  vec_t zero_v = '{raw: 16'h0, sign: 1'b0, hund: 4'd0, tens: 4'd0, units: 4'd0, tenth: 4'd0, err: 1'b0};

  initial begin
    int   pulses;
    int   v;
    logic [15:0] r;
    vec_t held;

    vecs[0] = '{raw: 16'h0550, sign: 1'b0, hund: 4'd0, tens: 4'd8, units: 4'd5, tenth: 4'd0, err: 1'b0};
    vecs[1] = '{raw: 16'hFC90, sign: 1'b1, hund: 4'd0, tens: 4'd5, units: 4'd5, tenth: 4'd0, err: 1'b0};
    vecs[2] = '{raw: 16'hFFF8, sign: 1'b1, hund: 4'd0, tens: 4'd0, units: 4'd0, tenth: 4'd5, err: 1'b0};
    vecs[3] = '{raw: 16'hFFFF, sign: 1'b0, hund: 4'd0, tens: 4'd0, units: 4'd0, tenth: 4'd0, err: 1'b0};
    vecs[4] = '{raw: 16'h07D0, sign: 1'b0, hund: 4'd1, tens: 4'd2, units: 4'd5, tenth: 4'd0, err: 1'b0};
    vecs[5] = '{raw: 16'h07D1, sign: 1'b0, hund: 4'd0, tens: 4'd0, units: 4'd0, tenth: 4'd0, err: 1'b1};
    vecs[6] = '{raw: 16'hFC8F, sign: 1'b0, hund: 4'd0, tens: 4'd0, units: 4'd0, tenth: 4'd0, err: 1'b1};
    for (int f = 0; f < 16; f++)
      vecs[7+f] = '{raw: 16'h0190 + 16'(f), sign: 1'b0, hund: 4'd0, tens: 4'd2, units: 4'd5,
                    tenth: 4'(tenth_tab[f]), err: 1'b0};

    rst_n     = 1'b0;
    raw_valid = 1'b0;
    raw       = 16'h0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset bcd_valid", bcd_valid, 0);
    check_outputs("reset", zero_v);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < N_VEC; i++) run_vec("table", vecs[i]);

    // Strobes at k+3 and in the DONE cycle must both be dropped.
    raw       = 16'h0550;
    raw_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    raw_valid = 1'b0;
    pulses    = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (bcd_valid) begin
        pulses++;
        check("drop pulse_cycle", c, 9);
      end
      raw       = 16'h07D0;
      raw_valid = (c == 2) || (c == 9);
    end
    raw_valid = 1'b0;
    check("drop pulse_count", pulses, 1);
    check_outputs("drop_hold", vecs[0]);
    check("drop idle busy", busy, 0);

    // Back-to-back: strobe on the first idle cycle after DONE is taken.
    run_vec("b2b_a", vecs[0]);
    run_vec("b2b_b", vecs[4]);

    // Reset pulse at edge k+5 aborts the conversion.
    raw       = 16'h0550;
    raw_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    raw_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort busy", busy, 0);
    check("abort bcd_valid", bcd_valid, 0);
    check_outputs("abort", zero_v);
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (bcd_valid) pulses++;
    end
    check("abort no_pulse", pulses, 0);
    held = '{raw: 16'h0191, sign: 1'b0, hund: 4'd0, tens: 4'd2, units: 4'd5, tenth: 4'd0, err: 1'b0};
    run_vec("post_abort", held);

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        v = int'($urandom_range(0, 2880)) - 880;
        r = v[15:0];
      end else begin
        r = 16'($urandom);
      end
      run_vec("rand", model(r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/temp_bcd_conv.md
Name: temp_bcd_conv

Overview:
- Sequential converter between the DS18B20 thermometer controller and the 7-segment decoders.
- Takes the controller's 16-bit two's-complement raw reading (1/16 °C per LSB) and produces sign, hundreds, tens, units and tenths BCD digits.
- Flags readings outside the sensor range of -55.0..+125.0 °C.
- Uses an iterative double-dabble (shift/add-3) for the integer part and a truncating table for tenths.

Parameters:
- INT_BITS, 7, width of the integer magnitude converted (0..127); sets the shift-cycle count.
- FRAC_BITS, 4, number of fractional bits in the raw reading.

Ports:
- clk  input  1  system clock (PLL output)
- rst_n  input  1  synchronous active-low reset
- raw_valid  input  1  one-cycle strobe, raw is valid
- raw  input  16  DS18B20 temperature word, two's complement, LSB = 0.0625 °C
- busy  output  1  conversion in progress; raw_valid ignored while high
- bcd_valid  output  1  one-cycle pulse, digit outputs updated this cycle
- sign  output  1  1 = negative value to display
- d_hund  output  4  hundreds digit, BCD
- d_tens  output  4  tens digit, BCD
- d_units  output  4  units digit, BCD
- d_tenth  output  4  tenths digit, BCD
- range_err  output  1  last accepted reading was out of range

Behaviour:
- Reset (rst_n low at a clk edge, any state): FSM to IDLE; all outputs 0; internal shift registers cleared. Reset mid-conversion aborts it, with no bcd_valid pulse.
- FSM states: IDLE, ABS, CONV, DONE.
- IDLE: busy=0. On raw_valid=1 at edge k, latch raw and go to ABS.
- ABS (1 cycle): mag = raw[15] ? -raw : raw, 16-bit modulo. Set range_err_next=1 if raw is signed > 0x07D0 (+125.0) or signed < 0xFC90 (-55.0). Load the double-dabble register with mag[10:4] and clear the BCD field. Compute tenths = floor(mag[3:0]*10/16) (0..9).
- CONV: exactly INT_BITS cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left one bit.
- DONE (1 cycle): register the outputs and assert bcd_valid=1 and busy=1, then go to IDLE.
- Latency: bcd_valid high in the cycle after edge k+2+INT_BITS, i.e. k+9 at default parameters.
- busy is high from edge k+1 through the DONE cycle. The earliest next acceptance is the edge ending the first IDLE cycle after DONE. raw_valid during ABS, CONV or DONE is dropped, with no queuing.
- Range error: d_* = 0, sign = 0, range_err = 1.
- Valid reading: range_err = 0.
- Sign rule: sign = raw[15] AND (any digit nonzero). This prevents "-0.0"; e.g. 0xFFFF (-0.0625) gives sign 0 with digits 0,0,0,0.
- Digit outputs hold their value between bcd_valid pulses. Only DONE updates them.
- The integer part is always <= 125 when in range, so d_hund is 0 or 1.

Decomposition:
- Package temp_disp_pkg holds:
  - the state enum (IDLE/ABS/CONV/DONE);
  - TEMP_MAX_RAW = 16'h07D0 and TEMP_MIN_RAW = 16'hFC90;
  - BCD_DIGIT_W = 4;
  - the 16-entry tenths lookup constant.
- One natural sub-module: bcd_add3, a combinational nibble corrector (>= 5 then +3), instantiated once per BCD nibble in the CONV datapath.
- FSM and registers stay in temp_bcd_conv.

Test Plan:
- raw=0x0550 strobed at edge k -> bcd_valid pulse at k+9 cycle; sign=0, digits 0,8,5,0, range_err=0; busy high k+1..k+9.
- raw=0xFC90 -> sign=1, digits 0,5,5,0. Then raw=0xFFF8 -> sign=1, digits 0,0,0,5. Then raw=0xFFFF -> sign=0, digits 0,0,0,0.
- raw=0x07D0 -> 1,2,5,0, range_err=0. Then raw=0x07D1 -> range_err=1, all digits 0, sign=0. Then raw=0xFC8F -> range_err=1.
- Fraction table sweep: raw=0x0190+f for f=0..15 -> d_tenth = floor(f*10/16), i.e. 0,0,1,1,2,3,3,4,5,5,6,6,7,8,8,9; integer digits 0,2,5.
- raw_valid=1 with 0x0550, then again with 0x07D0 at k+3 and in the DONE cycle -> only the 85.0 result appears and no second bcd_valid follows. A strobe on the first IDLE cycle after DONE is accepted.
- rst_n low for 1 cycle at k+5 of a conversion -> no bcd_valid, all outputs 0, busy=0 next cycle. A following raw=0x0191 yields 0,2,5,0.
